// File: rtl/gates_pkg.sv
// Shared definitions for the AND/OR/NOT gate block BIST.
//   NUM_VEC        : number of input vectors applied per run ({a,b} = 00..11)
//   state_e        : BIST controller states
//   gates_expected : golden response {a&b, a|b, ~a} for a given a/b pair
package gates_pkg;

    localparam int NUM_VEC = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [2:0] gates_expected(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/gates_bist_if.sv
// Link between the BIST engine and the gate block under test.
//   a, b  : gate inputs, driven by the BIST (master)
//   y_in  : gate response [2]=AND, [1]=OR, [0]=NOT a, driven by the gate block (slave)
interface gates_bist_if;
    logic       a;
    logic       b;
    logic [2:0] y_in;

    modport master (output a, output b, input y_in);
    modport slave  (input a, input b, output y_in);
endinterface

// File: rtl/gates_bist_hold_ctr.sv
// Hold counter for the BIST: counts cycles while en=1 and flags the last
// cycle of each vector hold.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable
//   tc         : terminal count, high while en=1 and count == HOLD_CYCLES-1
module gates_bist_hold_ctr #(
    parameter int HOLD_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gates_bist.sv
// Stimulus-and-check engine for the AND/OR/NOT gate block. Walks {a,b}
// through 00,01,10,11, holds each HOLD_CYCLES cycles, samples y_in on the
// last hold cycle and compares it against {a&b, a|b, ~a}.
//   clk, rst_n : clock, async active-low reset (aborts a run, clears results)
//   start      : launch a run; ignored while busy
//   gate       : master side of the gate link (a, b out; y_in in)
//   busy       : run in progress
//   done       : sticky completion flag, cleared by the next accepted start
//   pass       : valid with done; 1 iff no vector mismatched
//   err_count  : number of mismatching vectors in the last run
//   fail_vec   : bit i set if vector i mismatched
//
// state | meaning
// IDLE  | waiting for start, a=b=0, results held
// RUN   | applying vectors and checking responses
module gates_bist
    import gates_pkg::*;
#(
    parameter int HOLD_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    gates_bist_if.master       gate,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_count,
    output logic [NUM_VEC-1:0] fail_vec
);

    state_e             state_q;
    logic [1:0]         idx_q;
    logic               a_q;
    logic               b_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [2:0]         err_q;
    logic [NUM_VEC-1:0] fail_q;

    logic               start_acc;
    logic               tc;
    logic               mism;
    logic [NUM_VEC-1:0] cur_fail;
    logic [1:0]         idx_nxt;

    assign start_acc = (state_q == IDLE) && start;
    assign idx_nxt   = idx_q + 2'd1;

    // y_in is only looked at on the sample edge, so X/Z elsewhere is harmless.
    assign mism     = tc && (gate.y_in != gates_expected(a_q, b_q));
    assign cur_fail = mism ? (NUM_VEC'(1) << idx_q) : '0;

    gates_bist_hold_ctr #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc || tc),
        .en    (state_q == RUN),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= '0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (tc) begin
                        if (mism) begin
                            err_q  <= err_q + 3'd1;
                            fail_q <= fail_q | cur_fail;
                        end
                        if (idx_q != 2'(NUM_VEC - 1)) begin
                            idx_q      <= idx_nxt;
                            {a_q, b_q} <= idx_nxt;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // Include the vector being judged on this same edge.
                            pass_q  <= ((fail_q | cur_fail) == '0);
                            idx_q   <= '0;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gate.a    = a_q;
    assign gate.b    = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gates_bist.sv
module tb_gates_bist;
    import gates_pkg::*;

    logic clk;
    logic rst_n;
    logic start50;
    logic start1;
    int   fault50;
    int   fault1;

    logic       busy50, done50, pass50;
    logic [2:0] err50;
    logic [3:0] fv50;
    logic       busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;

    int n_tests;
    int n_fail;

    gates_bist_if if50 ();
    gates_bist_if if1 ();

    gates_bist #(.HOLD_CYCLES(50), .CNT_W(8)) u_dut50 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start50),
        .gate      (if50.master),
        .busy      (busy50),
        .done      (done50),
        .pass      (pass50),
        .err_count (err50),
        .fail_vec  (fv50)
    );

    gates_bist #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .gate      (if1.master),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_vec  (fv1)
    );

    // Gate block models: 0 = good, 1 = AND output stuck at 0, 2 = NOT output stuck at 1.
    always_comb begin
        if50.y_in = {if50.a & if50.b, if50.a | if50.b, ~if50.a};
        if (fault50 == 1) if50.y_in[2] = 1'b0;
        if (fault50 == 2) if50.y_in[0] = 1'b1;
    end

    always_comb begin
        if1.y_in = {if1.a & if1.b, if1.a | if1.b, ~if1.a};
        if (fault1 == 1) if1.y_in[2] = 1'b0;
        if (fault1 == 2) if1.y_in[0] = 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch the HOLD_CYCLES=50 instance and follow it to completion.
    task automatic run50(input int fault, input logic exp_pass,
                         input logic [2:0] exp_err, input logic [3:0] exp_fv);
        int seq_err;
        int early_done;
        fault50 = fault;
        seq_err = 0;
        early_done = 0;
        @(negedge clk);
        start50 = 1'b1;
        @(posedge clk);
        #1;
        start50 = 1'b0;
        check_val("e0_busy", 32'(busy50), 32'd1);
        check_val("e0_done_clr", 32'(done50), 32'd0);
        check_val("e0_err_clr", 32'(err50), 32'd0);
        check_val("e0_fv_clr", 32'(fv50), 32'd0);
        for (int k = 0; k < 200; k++) begin
            if ({if50.a, if50.b} !== 2'(k / 50)) seq_err++;
            if (done50 !== 1'b0) early_done++;
            @(posedge clk);
            #1;
        end
        check_val("ab_sequence", 32'(seq_err), 32'd0);
        check_val("done_early", 32'(early_done), 32'd0);
        check_val("done_at_200", 32'(done50), 32'd1);
        check_val("busy_end", 32'(busy50), 32'd0);
        check_val("pass", 32'(pass50), 32'(exp_pass));
        check_val("err_count", 32'(err50), 32'(exp_err));
        check_val("fail_vec", 32'(fv50), 32'(exp_fv));
        check_val("ab_idle", 32'({if50.a, if50.b}), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        start50 = 1'b0;
        start1  = 1'b0;
        fault50 = 0;
        fault1  = 0;
        rst_n   = 1'b0;
        #23;
        check_val("rst_busy", 32'(busy50), 32'd0);
        check_val("rst_done", 32'(done50), 32'd0);
        check_val("rst_pass", 32'(pass50), 32'd0);
        check_val("rst_err", 32'(err50), 32'd0);
        check_val("rst_fv", 32'(fv50), 32'd0);
        check_val("rst_ab", 32'({if50.a, if50.b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run50(0, 1'b1, 3'd0, 4'b0000);
        run50(1, 1'b0, 3'd1, 4'b1000);
        run50(2, 1'b0, 3'd2, 4'b1100);
        run50(0, 1'b1, 3'd0, 4'b0000);

        // HOLD_CYCLES=1 with a second start pulse while busy.
        begin
            int seq_err1;
            seq_err1 = 0;
            @(negedge clk);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            check_val("h1_busy", 32'(busy1), 32'd1);
            for (int k = 0; k < 4; k++) begin
                if ({if1.a, if1.b} !== 2'(k)) seq_err1++;
                if (done1 !== 1'b0) seq_err1++;
                start1 = (k == 1);
                @(posedge clk);
                #1;
            end
            start1 = 1'b0;
            check_val("h1_seq", 32'(seq_err1), 32'd0);
            check_val("h1_done_e4", 32'(done1), 32'd1);
            check_val("h1_pass", 32'(pass1), 32'd1);
            check_val("h1_err", 32'(err1), 32'd0);
            @(posedge clk);
            #1;
            check_val("h1_no_relaunch", 32'(busy1), 32'd0);
        end

        // Reset in the middle of vector 2 on the HOLD_CYCLES=50 instance.
        fault50 = 2;
        @(negedge clk);
        start50 = 1'b1;
        @(posedge clk);
        #1;
        start50 = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
        end
        check_val("mid_ab", 32'({if50.a, if50.b}), 32'd2);
        check_val("mid_busy", 32'(busy50), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_busy", 32'(busy50), 32'd0);
        check_val("async_ab", 32'({if50.a, if50.b}), 32'd0);
        check_val("async_done", 32'(done50), 32'd0);
        check_val("async_err", 32'(err50), 32'd0);
        check_val("async_fv", 32'(fv50), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run50(0, 1'b1, 3'd0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/gates_bist.md
Name: gates_bist

Overview:
- Sequential stimulus-and-check engine for the 3-output AND/OR/NOT gate block. It is the driving and monitoring end of that block's interface.
- It drives the gate inputs a and b through all four combinations, holding each for a programmable number of cycles.
- It samples the returned y[2:0] at the end of each hold and compares it against the expected {a&b, a|b, ~a}.
- It reports pass/fail, an error count and a per-vector failure map. It replaces the hand-written delay stimulus with a synthesizable self-test.

Parameters:
- HOLD_CYCLES, 50, clock cycles each input vector is held before sampling; legal range ≥1.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W ≥ HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a test run; sampled only when not busy.
- a  output  1  gate input a to DUT, registered.
- b  output  1  gate input b to DUT, registered.
- y_in  input  3  DUT response: [2]=AND, [1]=OR, [0]=NOT a.
- busy  output  1  high while a run is in progress.
- done  output  1  sticky: high after a run completes, until the next accepted start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  3  number of mismatching vectors in the last run (0..4).
- fail_vec  output  4  bit i set if vector i mismatched.

Behaviour:
- Reset, asynchronous on rst_n=0: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0, cnt=0. Reset mid-run aborts the run immediately; no partial results are retained.
- Vector order: idx 0..3 → {a,b} = idx[1:0], with a=idx[1]. Sequence is 00, 01, 10, 11.
- Expected response: exp = {a&b, a|b, ~a}, computed from the registered a and b currently driven.
- FSM states: IDLE, RUN.
- IDLE:
  - a=b=0, busy=0.
  - On start=1 at an edge: go to RUN; busy←1; idx←0; cnt←0; done←0; pass←0; err_count←0; fail_vec←0; {a,b}←00.
- RUN:
  - Each edge, cnt increments.
  - At the edge where cnt==HOLD_CYCLES-1, y_in is sampled and compared to exp.
  - On mismatch: err_count←err_count+1 and fail_vec[idx]←1.
  - If idx<3: idx←idx+1, cnt←0, {a,b} updates to the new idx in the same edge.
  - If idx==3: go to IDLE; busy←0; done←1; pass←(no mismatch in the whole run, including this vector); {a,b}←00.
- Latency: start accepted at edge E0 → busy=1 from E0 → done=1 from edge E0+4*HOLD_CYCLES.
  - Each vector is stable on a/b for exactly HOLD_CYCLES cycles.
  - DUT response must settle within HOLD_CYCLES-1 cycles; for a combinational DUT, HOLD_CYCLES=1 is valid.
- start while busy=1 is ignored. start held high continuously re-launches on the first edge in IDLE after done; done then clears on that edge.
- err_count never exceeds 4, so no saturation is needed.
- fail_vec and err_count are stable and readable while done=1.
- y_in is not used outside the sample edge; X/Z on y_in at other cycles has no effect.

Decomposition:
- Shared package gates_pkg:
  - NUM_VEC=4.
  - Function gates_expected(a,b) returning {a&b, a|b, ~a}.
  - State enum {IDLE, RUN}.
- One natural sub-module: gates_bist_hold_ctr, the HOLD_CYCLES counter with clear and terminal-count output. The FSM, the compare logic and the result registers stay in gates_bist.

Test Plan:
- Correct DUT (AND/OR/NOT model), HOLD_CYCLES=50, pulse start → a/b sequence 00, 01, 10, 11, each held 50 cycles; done=1 at E0+200; pass=1, err_count=0, fail_vec=0000.
- Faulty DUT with y[2] stuck at 0 → vector 3 fails; done=1, pass=0, err_count=1, fail_vec=1000.
- Faulty DUT with y[0] stuck at 1 → vectors 2 and 3 fail; err_count=2, fail_vec=1100.
- HOLD_CYCLES=1: start → done exactly 4 edges after E0; pass=1 with a correct DUT. A second start pulse during busy is ignored: a/b sequence unchanged, done still at E0+4.
- Assert rst_n=0 mid-run at vector 2 → all outputs 0 immediately (async). Release, then start → fresh full run with correct results.
- Run with fault, then re-run with correct DUT → the second accepted start clears done/err_count/fail_vec on E0; final pass=1, err_count=0.
